alu_arbiter: RTL

- Shares the single 16-bit `alu` between two requesters, e.g. the execute stage (port 0) and a branch/address helper (port 1).
- Round-robin grant; drives `alu` operands, op and imm combinationally from the granted requester.
- Tracks the in-flight tag across the ALU's one-cycle registered latency and returns the result to the owner.
- Keeps a private 3-bit {n,v,z} flag copy per requester, so one requester's ops never corrupt the other's flags.

---
 rtl/alu_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered-latency ALU between two requesters,
// keeping a private {n,v,z} flag copy per requester. Define ALU_ARB_LOCK_EN for lock priority.
module alu_arbiter #(
  parameter int DSIZE    = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_0,
  input  logic             req_1,
  input  logic [DSIZE-1:0] a_0,
  input  logic [DSIZE-1:0] b_0,
  input  logic [DSIZE-1:0] a_1,
  input  logic [DSIZE-1:0] b_1,
  input  logic [2:0]       op_0,
  input  logic [2:0]       op_1,
  input  logic [3:0]       imm_0,
  input  logic [3:0]       imm_1,
`ifdef ALU_ARB_LOCK_EN
  input  logic             lock_0,
  input  logic             lock_1,
`endif
  output logic             gnt_0,
  output logic             gnt_1,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [DSIZE-1:0] rsp_data,
  output logic [2:0]       flag_0,
  output logic [2:0]       flag_1,
  output logic [DSIZE-1:0] alu_a,
  output logic [DSIZE-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic [3:0]       alu_imm,
  output logic [2:0]       alu_last_flag,
  input  logic [DSIZE-1:0] alu_out,
  input  logic [2:0]       alu_flag
);

  logic       w_pri;
  logic       w_gnt_0;
  logic       w_gnt_1;
  logic       w_any_gnt;
  logic       r_last_grant;
  logic       r_inflight_valid;
  logic       r_inflight_id;
  logic       r_inflight_flagop;
  logic [2:0] r_flag_0;
  logic [2:0] r_flag_1;

`ifdef ALU_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [CW-1:0] r_lock_cnt;
  logic          r_lock_hold;
  logic          w_lock_at_max;
  logic          w_gnt_lock;

  // A locked owner keeps contention priority until the counter saturates.
  assign w_lock_at_max = (r_lock_cnt == CW'(LOCK_MAX));
  assign w_pri         = (r_lock_hold && !w_lock_at_max) ? r_last_grant : ~r_last_grant;
  assign w_gnt_lock    = (w_gnt_0 && lock_0) || (w_gnt_1 && lock_1);
`else
  logic w_unused_lock_max;

  assign w_unused_lock_max = (LOCK_MAX > 0);
  assign w_pri             = ~r_last_grant;
`endif

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    w_gnt_0 = 1'b0;
    w_gnt_1 = 1'b0;
    if (rst_n) begin
      if (req_0 && req_1) begin
        w_gnt_0 = ~w_pri;
        w_gnt_1 = w_pri;
      end else begin
        w_gnt_0 = req_0;
        w_gnt_1 = req_1;
      end
    end
  end

  assign w_any_gnt = w_gnt_0 | w_gnt_1;

  // Idle cycles present an ADD of zero; imm and lastFlag follow port 0.
  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_op        = 3'd0;
    alu_imm       = imm_0;
    alu_last_flag = r_flag_0;
    if (w_gnt_1) begin
      alu_a         = a_1;
      alu_b         = b_1;
      alu_op        = op_1;
      alu_imm       = imm_1;
      alu_last_flag = r_flag_1;
    end else if (w_gnt_0) begin
      alu_a  = a_0;
      alu_b  = b_0;
      alu_op = op_0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_last_grant      <= 1'b1;
      r_inflight_valid  <= 1'b0;
      r_inflight_id     <= 1'b0;
      r_inflight_flagop <= 1'b0;
      r_flag_0          <= 3'b000;
      r_flag_1          <= 3'b000;
    end else begin
      r_inflight_valid <= w_any_gnt;
      if (w_any_gnt) begin
        r_inflight_id     <= w_gnt_1;
        r_inflight_flagop <= ~alu_op[2];
        r_last_grant      <= w_gnt_1;
      end
      // Shifts and rotates leave the owner's flags alone; the other copy is never written.
      if (r_inflight_valid && r_inflight_flagop) begin
        if (r_inflight_id) r_flag_1 <= alu_flag;
        else               r_flag_0 <= alu_flag;
      end
    end
  end

`ifdef ALU_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock_cnt  <= '0;
      r_lock_hold <= 1'b0;
    end else if (w_gnt_lock && !w_lock_at_max) begin
      r_lock_cnt  <= r_lock_cnt + 1'b1;
      r_lock_hold <= 1'b1;
    end else begin
      r_lock_cnt  <= '0;
      r_lock_hold <= 1'b0;
    end
  end
`endif

  assign gnt_0     = w_gnt_0;
  assign gnt_1     = w_gnt_1;
  assign rsp_valid = r_inflight_valid;
  assign rsp_id    = r_inflight_id;
  assign rsp_data  = alu_out;
  assign flag_0    = r_flag_0;
  assign flag_1    = r_flag_1;

endmodule
